boss_attack_controller: RTL

Generates the boss's attack timing for the special stages and drives the direction-change inputs of the boss movement block. A frame-paced state machine runs a pseudo-random cooldown, then a visible charge phase. It then requests a shot from the missile spawner over a req/ack handshake. Each accepted shot emits a one-cycle switch_direction_pulse and a latched random_axis, which the movement block uses to reverse the boss's X or Y speed.

---
 rtl/boss_attack_controller.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/boss_attack_controller.sv
// boss_attack_controller
//   Frame-paced boss attack sequencer for the special stages. Runs a
//   pseudo-random cooldown, then a visible charge phase, then requests a
//   shot from the missile spawner over a req/ack handshake. Each accepted
//   shot produces a one-cycle switch_direction_pulse and a latched
//   random_axis for the boss movement block.
//
// Optional feature macro: BOSS_RAGE_EN
//   When defined, a cooldown load taken while boss_low_health is high is
//   halved (never below 1 frame). When undefined, boss_low_health is ignored.
//
// Ports:
//   clk                    system clock
//   resetN                 asynchronous active-low reset
//   startOfFrame           one-cycle pulse per video frame
//   enable                 boss alive and stage active
//   fire_ack               missile spawner accepted the shot (FIRE only)
//   boss_low_health        rage request (BOSS_RAGE_EN builds only)
//   fire_req               shot request, held until ack or timeout
//   charging               high during CHARGE (sprite flash)
//   switch_direction_pulse one-cycle pulse per accepted shot
//   random_axis            axis select for movement: 1 = Y, 0 = X
//   state_dbg              current state encoding (IDLE=0 .. FIRE=3)
module boss_attack_controller #(
  parameter int          MIN_COOLDOWN        = 30,
  parameter int          COOLDOWN_RANGE_BITS = 5,
  parameter int          CHARGE_FRAMES       = 10,
  parameter int          ACK_TIMEOUT         = 8,
  parameter logic [15:0] LFSR_SEED           = 16'hACE1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       enable,
  input  logic       fire_ack,
  input  logic       boss_low_health,
  output logic       fire_req,
  output logic       charging,
  output logic       switch_direction_pulse,
  output logic       random_axis,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COOLDOWN = 2'd1,
    ST_CHARGE   = 2'd2,
    ST_FIRE     = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  state_t      state_r;
  logic [9:0]  counter_r;
  logic [15:0] lfsr_r;
  logic [9:0]  load_base_s;
  logic [9:0]  load_s;

  // One step of the 16-bit Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    if (v[0]) begin
      return (v >> 1) ^ LFSR_MASK;
    end else begin
      return v >> 1;
    end
  endfunction

  // Cooldown load value; always taken from the pre-step LFSR value.
  always_comb begin
    load_base_s = 10'(MIN_COOLDOWN)
                + {{(10-COOLDOWN_RANGE_BITS){1'b0}}, lfsr_r[COOLDOWN_RANGE_BITS-1:0]};
`ifdef BOSS_RAGE_EN
    if (boss_low_health) begin
      if ((load_base_s >> 1) == 10'd0) begin
        load_s = 10'd1;
      end else begin
        load_s = load_base_s >> 1;
      end
    end else begin
      load_s = load_base_s;
    end
`else
    load_s = load_base_s;
`endif
  end

`ifndef BOSS_RAGE_EN
  // The rage input has no function in this build.
  logic unused_s;
  assign unused_s = boss_low_health;
`endif

  // Free-running frame-paced LFSR; steps in every state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lfsr_r <= LFSR_SEED;
    end else if (startOfFrame) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  // Attack FSM with registered outputs. The counter is shared by all timed
  // states: it is loaded with N on entry and the exit fires on the frame
  // pulse that finds it at 1, i.e. the Nth pulse after entry.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r                <= ST_IDLE;
      counter_r              <= 10'd0;
      fire_req               <= 1'b0;
      charging               <= 1'b0;
      switch_direction_pulse <= 1'b0;
      random_axis            <= 1'b0;
    end else begin
      switch_direction_pulse <= 1'b0;
      if (!enable) begin
        // Highest priority: abort everything, random_axis holds.
        state_r   <= ST_IDLE;
        counter_r <= 10'd0;
        fire_req  <= 1'b0;
        charging  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r   <= ST_COOLDOWN;
            counter_r <= load_s;
          end
          ST_COOLDOWN: begin
            if (startOfFrame) begin
              if (counter_r == 10'd1) begin
                state_r   <= ST_CHARGE;
                counter_r <= 10'(CHARGE_FRAMES);
                charging  <= 1'b1;
              end else begin
                counter_r <= counter_r - 10'd1;
              end
            end
          end
          ST_CHARGE: begin
            if (startOfFrame) begin
              if (counter_r == 10'd1) begin
                state_r   <= ST_FIRE;
                counter_r <= 10'(ACK_TIMEOUT);
                charging  <= 1'b0;
                fire_req  <= 1'b1;
              end else begin
                counter_r <= counter_r - 10'd1;
              end
            end
          end
          ST_FIRE: begin
            // An ack beats a timeout landing on the same edge.
            if (fire_ack) begin
              state_r                <= ST_COOLDOWN;
              counter_r              <= load_s;
              fire_req               <= 1'b0;
              switch_direction_pulse <= 1'b1;
              random_axis            <= lfsr_r[15];
            end else if (startOfFrame) begin
              if (counter_r == 10'd1) begin
                state_r   <= ST_COOLDOWN;
                counter_r <= load_s;
                fire_req  <= 1'b0;
              end else begin
                counter_r <= counter_r - 10'd1;
              end
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            counter_r <= 10'd0;
            fire_req  <= 1'b0;
            charging  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state_dbg = state_r;

endmodule
